instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 220 ++++++++++++++++++++++
 tb/tb_instr_encoder.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// instr_encoder
//   Turns an abstract operation request (op code, register indices, immediate)
//   into an RV32I instruction word and hands it to an instruction-memory writer
//   together with the word-aligned address it should be stored at.
//
//   Pipeline: request accepted -> encode stage register -> 4-entry output FIFO.
//   Requests whose op code is unknown or whose immediate is out of range are
//   still accepted and consume an address, but are emitted as a NOP and raise
//   the sticky err flag.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   request handshake
//   in_op               operation code (0..36 legal)
//   in_rd/in_rs1/in_rs2 register indices
//   in_imm              immediate (two's complement; full value for U-type)
//   base_addr/addr_load address counter load (bits [1:0] ignored)
//   out_valid/out_ready output handshake
//   out_instr/out_addr  encoded word and its address (FIFO head)
//   err/err_clr         sticky illegal-request flag and its clear
module instr_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  in_op,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    input  logic [31:0] base_addr,
    input  logic        addr_load,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        err,
    input  logic        err_clr
);

    localparam logic [31:0] NOP_WORD   = 32'h0000_0013;
    localparam logic [6:0]  OPC_R      = 7'b0110011;
    localparam logic [6:0]  OPC_IALU   = 7'b0010011;
    localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
    localparam logic [6:0]  OPC_STORE  = 7'b0100011;
    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
    localparam logic [6:0]  OPC_JAL    = 7'b1101111;
    localparam logic [6:0]  OPC_JALR   = 7'b1100111;
    localparam logic [6:0]  OPC_LUI    = 7'b0110111;
    localparam logic [6:0]  OPC_AUIPC  = 7'b0010111;

    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] enc_word;
    logic        enc_legal;
    logic [31:0] final_word;

    // Immediate range tests: a value fits N signed bits when every bit from
    // N-1 upward is a copy of the sign.
    logic fits12, fits13, fits21, shamt_ok, u_ok;
    assign fits12   = (&in_imm[31:11]) | ~(|in_imm[31:11]);
    assign fits13   = (&in_imm[31:12]) | ~(|in_imm[31:12]);
    assign fits21   = (&in_imm[31:20]) | ~(|in_imm[31:20]);
    assign shamt_ok = ~(|in_imm[31:5]);
    assign u_ok     = ~(|in_imm[11:0]);

    // Low address bits are forced to zero, so they are intentionally unused.
    logic unused_base_bits;
    assign unused_base_bits = &{1'b0, base_addr[1:0]};

    always_comb begin
        funct3 = 3'b000;
        case (in_op)
            6'd5, 6'd14, 6'd20, 6'd25, 6'd28:         funct3 = 3'b001;
            6'd8, 6'd17, 6'd21, 6'd26:                funct3 = 3'b010;
            6'd9, 6'd18:                              funct3 = 3'b011;
            6'd4, 6'd13, 6'd22, 6'd29:                funct3 = 3'b100;
            6'd6, 6'd7, 6'd15, 6'd16, 6'd23, 6'd30:   funct3 = 3'b101;
            6'd3, 6'd12, 6'd31:                       funct3 = 3'b110;
            6'd2, 6'd11, 6'd32:                       funct3 = 3'b111;
            default:                                  funct3 = 3'b000;
        endcase
    end

    // SUB, SRA and SRAI are the only ops with the alternate funct7.
    assign funct7 = (in_op == 6'd1 || in_op == 6'd7 || in_op == 6'd16) ? 7'b0100000 : 7'b0000000;

    always_comb begin
        enc_word  = NOP_WORD;
        enc_legal = 1'b0;
        case (in_op)
            6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9: begin
                enc_word  = {funct7, in_rs2, in_rs1, funct3, in_rd, OPC_R};
                enc_legal = 1'b1;
            end
            6'd10, 6'd11, 6'd12, 6'd13, 6'd17, 6'd18: begin
                enc_word  = {in_imm[11:0], in_rs1, funct3, in_rd, OPC_IALU};
                enc_legal = fits12;
            end
            6'd14, 6'd15, 6'd16: begin
                enc_word  = {funct7, in_imm[4:0], in_rs1, funct3, in_rd, OPC_IALU};
                enc_legal = shamt_ok;
            end
            6'd19, 6'd20, 6'd21, 6'd22, 6'd23: begin
                enc_word  = {in_imm[11:0], in_rs1, funct3, in_rd, OPC_LOAD};
                enc_legal = fits12;
            end
            6'd24, 6'd25, 6'd26: begin
                enc_word  = {in_imm[11:5], in_rs2, in_rs1, funct3, in_imm[4:0], OPC_STORE};
                enc_legal = fits12;
            end
            6'd27, 6'd28, 6'd29, 6'd30, 6'd31, 6'd32: begin
                enc_word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, funct3,
                             in_imm[4:1], in_imm[11], OPC_BRANCH};
                enc_legal = fits13 & ~in_imm[0];
            end
            6'd33: begin
                enc_word  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OPC_JAL};
                enc_legal = fits21 & ~in_imm[0];
            end
            6'd34: begin
                enc_word  = {in_imm[11:0], in_rs1, 3'b000, in_rd, OPC_JALR};
                enc_legal = fits12;
            end
            6'd35: begin
                enc_word  = {in_imm[31:12], in_rd, OPC_LUI};
                enc_legal = u_ok;
            end
            6'd36: begin
                enc_word  = {in_imm[31:12], in_rd, OPC_AUIPC};
                enc_legal = u_ok;
            end
            default: begin
                enc_word  = NOP_WORD;
                enc_legal = 1'b0;
            end
        endcase
    end

    assign final_word = enc_legal ? enc_word : NOP_WORD;

    // ---------------------------------------------------------------------
    // Handshake, address counter, error flag, encode stage and FIFO control
    // ---------------------------------------------------------------------
    logic        stage_valid_reg;
    logic [31:0] stage_instr_reg;
    logic [31:0] stage_addr_reg;
    logic [31:0] addr_reg;
    logic        err_reg;
    logic [1:0]  wr_ptr_reg;
    logic [1:0]  rd_ptr_reg;
    logic [2:0]  count_reg;
    logic [31:0] fifo_instr_mem [0:3];
    logic [31:0] fifo_addr_mem  [0:3];

    logic        accept;
    logic        push;
    logic        pop;
    logic [31:0] load_addr;
    logic [31:0] take_addr;

    // The encode-stage entry counts against capacity, so whatever is accepted
    // always has a FIFO slot waiting for it. A pop in the same cycle is not
    // credited, keeping in_ready a pure function of registered state.
    assign in_ready  = ~rst & ((count_reg + {2'b00, stage_valid_reg}) < 3'd4);
    assign accept    = in_valid & in_ready;
    assign push      = stage_valid_reg;
    assign pop       = out_valid & out_ready;
    assign load_addr = {base_addr[31:2], 2'b00};
    assign take_addr = addr_load ? load_addr : addr_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_valid_reg <= 1'b0;
            addr_reg        <= 32'h0;
            err_reg         <= 1'b0;
            wr_ptr_reg      <= 2'd0;
            rd_ptr_reg      <= 2'd0;
            count_reg       <= 3'd0;
        end else begin
            stage_valid_reg <= accept;
            if (accept) begin
                addr_reg <= take_addr + 32'd4;
            end else if (addr_load) begin
                addr_reg <= load_addr;
            end
            // An illegal acceptance takes priority over a simultaneous clear.
            if (accept & ~enc_legal) begin
                err_reg <= 1'b1;
            end else if (err_clr) begin
                err_reg <= 1'b0;
            end
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 2'd1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 2'd1;
            end
            count_reg <= count_reg + {2'b00, push} - {2'b00, pop};
        end
    end

    // Data path registers carry no reset; validity is tracked separately.
    always_ff @(posedge clk) begin
        if (accept) begin
            stage_instr_reg <= final_word;
            stage_addr_reg  <= take_addr;
        end
        if (push) begin
            fifo_instr_mem[wr_ptr_reg] <= stage_instr_reg;
            fifo_addr_mem[wr_ptr_reg]  <= stage_addr_reg;
        end
    end

    assign out_valid = (count_reg != 3'd0);
    assign out_instr = fifo_instr_mem[rd_ptr_reg];
    assign out_addr  = fifo_addr_mem[rd_ptr_reg];
    assign err       = err_reg;

endmodule

// File: tb/tb_instr_encoder.sv
// Testbench for instr_encoder: directed cases plus randomized traffic, checked
// by a scoreboard fed from a behavioural reference model.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  in_op = 6'd0;
    logic [4:0]  in_rd = 5'd0;
    logic [4:0]  in_rs1 = 5'd0;
    logic [4:0]  in_rs2 = 5'd0;
    logic [31:0] in_imm = 32'd0;
    logic [31:0] base_addr = 32'd0;
    logic        addr_load = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        err;
    logic        err_clr = 1'b0;

    instr_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_imm    (in_imm),
        .base_addr (base_addr),
        .addr_load (addr_load),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_addr  (out_addr),
        .err       (err),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] addr_m = 32'd0;
    logic        err_m  = 1'b0;

    // funct3 for op codes 0..36, straight from the RV32I instruction tables.
    int f3_tab [0:36] = '{0,0,7,6,4,1,5,5,2,3,
                          0,7,6,4,1,5,5,2,3,
                          0,1,2,4,5,
                          0,1,2,
                          0,1,4,5,6,7,
                          0,0,0,0};

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Reference encoder: returns {illegal, word}. Legality uses plain signed
    // integer ranges; fields are placed by shift-and-mask arithmetic.
    function automatic logic [32:0] ref_encode(input logic [5:0] op, input logic [4:0] rd,
                                               input logic [4:0] rs1, input logic [4:0] rs2,
                                               input logic [31:0] imm);
        longint      s;
        int          o;
        bit          ok;
        logic [31:0] w, im, f3, r_d, r_s1, r_s2;
        s    = longint'($signed(imm));
        o    = int'(op);
        im   = imm;
        r_d  = 32'(rd);
        r_s1 = 32'(rs1);
        r_s2 = 32'(rs2);
        f3   = (o <= 36) ? 32'(f3_tab[o]) : 32'd0;
        ok   = 1'b1;
        w    = 32'd0;
        if (o <= 9) begin
            w = (((o == 1) || (o == 7)) ? 32'h4000_0000 : 32'd0)
                | (r_s2 << 20) | (r_s1 << 15) | (f3 << 12) | (r_d << 7) | 32'h33;
        end else if ((o >= 10 && o <= 13) || o == 17 || o == 18) begin
            ok = (s >= -2048) && (s <= 2047);
            w  = ((im & 32'hFFF) << 20) | (r_s1 << 15) | (f3 << 12) | (r_d << 7) | 32'h13;
        end else if (o >= 14 && o <= 16) begin
            ok = (s >= 0) && (s <= 31);
            w  = ((o == 16) ? 32'h4000_0000 : 32'd0) | ((im & 32'h1F) << 20)
                 | (r_s1 << 15) | (f3 << 12) | (r_d << 7) | 32'h13;
        end else if (o >= 19 && o <= 23) begin
            ok = (s >= -2048) && (s <= 2047);
            w  = ((im & 32'hFFF) << 20) | (r_s1 << 15) | (f3 << 12) | (r_d << 7) | 32'h03;
        end else if (o >= 24 && o <= 26) begin
            ok = (s >= -2048) && (s <= 2047);
            w  = (((im >> 5) & 32'h7F) << 25) | (r_s2 << 20) | (r_s1 << 15) | (f3 << 12)
                 | ((im & 32'h1F) << 7) | 32'h23;
        end else if (o >= 27 && o <= 32) begin
            ok = (s >= -4096) && (s <= 4094) && ((im & 32'd1) == 32'd0);
            w  = (((im >> 12) & 32'd1) << 31) | (((im >> 5) & 32'h3F) << 25) | (r_s2 << 20)
                 | (r_s1 << 15) | (f3 << 12) | (((im >> 1) & 32'hF) << 8)
                 | (((im >> 11) & 32'd1) << 7) | 32'h63;
        end else if (o == 33) begin
            ok = (s >= -1048576) && (s <= 1048574) && ((im & 32'd1) == 32'd0);
            w  = (((im >> 20) & 32'd1) << 31) | (((im >> 1) & 32'h3FF) << 21)
                 | (((im >> 11) & 32'd1) << 20) | (((im >> 12) & 32'hFF) << 12)
                 | (r_d << 7) | 32'h6F;
        end else if (o == 34) begin
            ok = (s >= -2048) && (s <= 2047);
            w  = ((im & 32'hFFF) << 20) | (r_s1 << 15) | (r_d << 7) | 32'h67;
        end else if (o == 35 || o == 36) begin
            ok = ((im & 32'hFFF) == 32'd0);
            w  = (im & 32'hFFFF_F000) | (r_d << 7) | ((o == 35) ? 32'h37 : 32'h17);
        end else begin
            ok = 1'b0;
        end
        if (!ok) w = 32'h0000_0013;
        return {~ok, w};
    endfunction

    // Model: decides acceptance, tracks the address counter and err, and
    // pushes expected outputs. Runs at the falling edge, ahead of the monitor.
    always @(negedge clk) begin
        logic        exp_ready;
        logic        acc;
        logic [31:0] take;
        logic [32:0] r;
        exp_ready = !rst && (sb_q.size() < 4);
        check("in_ready", 32'(in_ready), 32'(exp_ready));
        check("err", 32'(err), 32'(err_m));
        if (rst) begin
            sb_q.delete();
            addr_m = 32'd0;
            err_m  = 1'b0;
        end else begin
            acc  = in_valid && exp_ready;
            take = addr_load ? {base_addr[31:2], 2'b00} : addr_m;
            r    = ref_encode(in_op, in_rd, in_rs1, in_rs2, in_imm);
            if (acc) begin
                sb_q.push_back('{instr: r[31:0], addr: take});
                addr_m = take + 32'd4;
            end else if (addr_load) begin
                addr_m = take;
            end
            if (acc && r[32]) err_m = 1'b1;
            else if (err_clr) err_m = 1'b0;
        end
    end

    // Monitor: compares the FIFO head whenever out_valid, pops on handshake.
    always @(negedge clk) begin
        #2;
        if (!rst && out_valid) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got instr %h addr %h expected no output", out_instr, out_addr);
            end else begin
                check("out_instr", out_instr, sb_q[0].instr);
                check("out_addr", out_addr, sb_q[0].addr);
                if (out_ready) begin
                    $display("xfer addr=%h instr=%h", out_addr, out_instr);
                    void'(sb_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm,
                        input logic ld, input logic [31:0] base);
        int   n;
        logic acc;
        n   = 0;
        acc = 1'b0;
        in_valid  = 1'b1;
        in_op     = 6'(op);
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_imm    = imm;
        addr_load = ld;
        base_addr = base;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            tick();
            n++;
        end
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got no acceptance expected acceptance within 50 cycles");
        end
        in_valid  = 1'b0;
        addr_load = 1'b0;
    endtask

    // Waits for the next output word (out_ready assumed high), compares it,
    // and reports how many falling edges it took to appear.
    task automatic wait_out(input string name, input logic [31:0] exp_instr,
                            input logic [31:0] exp_addr, output int lat);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        check({name, "_valid"}, 32'(out_valid), 32'd1);
        check({name, "_instr"}, out_instr, exp_instr);
        check({name, "_addr"}, out_addr, exp_addr);
        lat = n;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        tick();
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (sb_q.size() != 0 && n < 60) begin
            tick();
            n++;
        end
        check("drain_left", 32'(sb_q.size()), 32'd0);
    endtask

    function automatic logic [31:0] rand_imm();
        logic [31:0] v;
        case ($urandom % 6)
            0:       v = $urandom;
            1:       v = $urandom_range(0, 4095) - 32'd2048;
            2:       v = ($urandom_range(0, 8191) - 32'd4096) & 32'hFFFF_FFFE;
            3:       v = $urandom & 32'hFFFF_F000;
            4:       v = ($urandom_range(0, 2097151) - 32'd1048576) & 32'hFFFF_FFFE;
            default: v = $urandom_range(0, 40);
        endcase
        return v;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        out_ready = 1'b1;
        do_reset();

        // Basic encodings and first-word latency.
        send(10, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 32'd0);
        wait_out("addi", 32'h0050_0093, 32'h0, lat);
        check("addi_latency", 32'(lat), 32'd2);
        send(26, 5'd0, 5'd3, 5'd2, 32'd8, 1'b0, 32'd0);
        wait_out("sw", 32'h0021_A423, 32'h4, lat);
        send(35, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 1'b0, 32'd0);
        wait_out("lui", 32'h1234_52B7, 32'h8, lat);
        send(1, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 32'd0);
        wait_out("sub", 32'h4031_00B3, 32'hC, lat);

        // Illegal requests become NOPs and set err until cleared.
        send(27, 5'd0, 5'd1, 5'd2, 32'd3, 1'b0, 32'd0);
        wait_out("beq_odd", 32'h0000_0013, 32'h10, lat);
        check("err_after_beq", 32'(err), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        @(negedge clk);
        check("err_cleared", 32'(err), 32'd0);
        tick();
        send(10, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0, 32'd0);
        wait_out("addi_2048", 32'h0000_0013, 32'h14, lat);
        check("err_after_addi", 32'(err), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // Back-pressure: only four requests fit while the consumer stalls.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(0, 5'(i + 1), 5'(i), 5'(i + 2), 32'd0, 1'b0, 32'd0);
        in_valid = 1'b1;
        in_op    = 6'd2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("full_in_ready", 32'(in_ready), 32'd0);
            check("full_out_valid", 32'(out_valid), 32'd1);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        send(3, 5'd7, 5'd8, 5'd9, 32'd0, 1'b0, 32'd0);
        send(4, 5'd10, 5'd11, 5'd12, 32'd0, 1'b0, 32'd0);
        drain();

        // Address load, alignment and wrap.
        send(10, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 32'h0000_0103);
        wait_out("load_base", 32'h0050_0093, 32'h100, lat);
        send(10, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 32'd0);
        wait_out("after_load", 32'h0050_0093, 32'h104, lat);
        send(10, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 32'hFFFF_FFFC);
        wait_out("load_top", 32'h0050_0093, 32'hFFFF_FFFC, lat);
        send(10, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 32'd0);
        wait_out("wrap", 32'h0050_0093, 32'h0, lat);

        // Reset with entries in flight discards them.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(5, 5'd3, 5'd4, 5'd5, 32'd0, 1'b0, 32'd0);
        do_reset();
        out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_empty", 32'(out_valid), 32'd0);
        tick();
        send(10, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 32'd0);
        wait_out("post_rst", 32'h0050_0093, 32'h0, lat);

        // Randomized traffic with random back-pressure, loads and clears.
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom % 4) != 0;
            in_op     = 6'($urandom_range(0, 40));
            in_rd     = 5'($urandom);
            in_rs1    = 5'($urandom);
            in_rs2    = 5'($urandom);
            in_imm    = rand_imm();
            addr_load = ($urandom % 16) == 0;
            base_addr = $urandom;
            err_clr   = ($urandom % 8) == 0;
            out_ready = ($urandom % 4) != 0;
            tick();
        end
        addr_load = 1'b0;
        err_clr   = 1'b0;
        drain();
        @(negedge clk);
        check("final_out_valid", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
